// File: rtl/sddr_pkg.sv
// rtl/sddr_pkg.sv - shared DDR geometry, line-buffer states and byte-merge helper
`timescale 1ns/1ps
package sddr_pkg;

  localparam int DDR_BANK_BITS    = 3;
  localparam int DDR_ROW_BITS     = 13;
  localparam int DDR_COL_BITS     = 10;
  localparam int DDR_DATA_BITS    = 16;
  localparam int DDR_BURST_LENGTH = 8;

  localparam int ADDRESS_BITS = DDR_BANK_BITS + DDR_ROW_BITS + DDR_COL_BITS + $clog2(DDR_DATA_BITS / 8);
  localparam int LINE_BITS    = DDR_BURST_LENGTH * DDR_DATA_BITS;
  localparam int OFS_BITS     = $clog2(LINE_BITS / 8);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_WB_WAIT,
    ST_FILL_REQ,
    ST_FILL_WAIT,
    ST_RESPOND
  } state_e;

  function automatic logic [LINE_BITS-1:0] merge_word(
    input logic [LINE_BITS-1:0]  line,
    input logic [OFS_BITS-3:0]   word_idx,
    input logic [31:0]           wdata,
    input logic [3:0]            be
  );
    logic [LINE_BITS-1:0] merged;
    merged = line;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[32*int'(word_idx) + 8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sddr_line_buffer.sv
// rtl/sddr_line_buffer.sv - single-line write-back buffer between CPU word port and DDR bursts
`timescale 1ns/1ps
module sddr_line_buffer #(
  parameter int BANK_BITS    = 3,
  parameter int ROW_BITS     = 13,
  parameter int COL_BITS     = 10,
  parameter int DATA_BITS    = 16,
  parameter int BURST_LENGTH = 8,
  localparam int ADDRESS_BITS = BANK_BITS + ROW_BITS + COL_BITS + $clog2(DATA_BITS / 8),
  localparam int LINE_BITS    = BURST_LENGTH * DATA_BITS,
  localparam int OFS_BITS     = $clog2(LINE_BITS / 8)
) (
  input  logic                    cpu_clock_i,
  input  logic                    reset_i,
  input  logic                    cpu_req_valid_i,
  output logic                    cpu_req_ready_o,
  input  logic [ADDRESS_BITS-1:0] cpu_req_addr_i,
  input  logic                    cpu_req_write_i,
  input  logic [31:0]             cpu_req_wdata_i,
  input  logic [3:0]              cpu_req_be_i,
  output logic                    cpu_rsp_valid_o,
  output logic [31:0]             cpu_rsp_rdata_o,
  input  logic                    flush_i,
  output logic                    flush_done_o,
  output logic                    data_cmd_valid_o,
  output logic [ADDRESS_BITS-1:0] data_cmd_address_o,
  output logic                    data_cmd_write_o,
  input  logic                    data_cmd_ack_i,
  output logic [LINE_BITS-1:0]    data_cmd_data_o,
  input  logic                    data_rsp_ready_i,
  input  logic [LINE_BITS-1:0]    data_data_i
);
  import sddr_pkg::*;

  localparam int TAG_BITS = ADDRESS_BITS - OFS_BITS;
  localparam int IDX_BITS = OFS_BITS - 2;

  state_e               state_q, state_d;
  logic [LINE_BITS-1:0] line_q;
  logic [TAG_BITS-1:0]  tag_q, req_tag_q;
  logic [IDX_BITS-1:0]  req_idx_q;
  logic                 valid_q, dirty_q, flushing_q, flush_done_q;
  logic                 req_write_q;
  logic [31:0]          req_wdata_q;
  logic [3:0]           req_be_q;

  logic [TAG_BITS-1:0]  cpu_tag;
  logic [IDX_BITS-1:0]  cpu_idx;
  logic                 hit;
  logic                 addr_unused;

  assign cpu_tag     = cpu_req_addr_i[ADDRESS_BITS-1:OFS_BITS];
  assign cpu_idx     = cpu_req_addr_i[OFS_BITS-1:2];
  assign hit         = valid_q && (cpu_tag == tag_q);
  assign addr_unused = ^cpu_req_addr_i[1:0];

  assign flush_done_o    = flush_done_q;
  assign data_cmd_data_o = line_q;

  always_comb begin
    state_d            = state_q;
    cpu_req_ready_o    = 1'b0;
    cpu_rsp_valid_o    = 1'b0;
    cpu_rsp_rdata_o    = '0;
    data_cmd_valid_o   = 1'b0;
    data_cmd_address_o = '0;
    data_cmd_write_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cpu_req_ready_o = !flush_i;
        if (flush_i) begin
          if (valid_q && dirty_q) state_d = ST_WB_REQ;
        end else if (cpu_req_valid_i) begin
          if (hit)                     state_d = ST_RESPOND;
          else if (valid_q && dirty_q) state_d = ST_WB_REQ;
          else                         state_d = ST_FILL_REQ;
        end
      end
      ST_WB_REQ: begin
        data_cmd_valid_o   = 1'b1;
        data_cmd_write_o   = 1'b1;
        data_cmd_address_o = {tag_q, {OFS_BITS{1'b0}}};
        if (data_cmd_ack_i) state_d = ST_WB_WAIT;
      end
      ST_WB_WAIT: begin
        if (data_rsp_ready_i) state_d = flushing_q ? ST_IDLE : ST_FILL_REQ;
      end
      ST_FILL_REQ: begin
        data_cmd_valid_o   = 1'b1;
        data_cmd_address_o = {req_tag_q, {OFS_BITS{1'b0}}};
        if (data_cmd_ack_i) state_d = ST_FILL_WAIT;
      end
      ST_FILL_WAIT: begin
        if (data_rsp_ready_i) state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        cpu_rsp_valid_o = 1'b1;
        cpu_rsp_rdata_o = line_q[32*int'(req_idx_q) +: 32];
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      line_q       <= '0;
      tag_q        <= '0;
      valid_q      <= 1'b0;
      dirty_q      <= 1'b0;
      flushing_q   <= 1'b0;
      flush_done_q <= 1'b0;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      req_write_q  <= 1'b0;
      req_wdata_q  <= '0;
      req_be_q     <= '0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (flush_i) begin
            // A clean flush completes here; a dirty one finishes after its writeback.
            flushing_q <= valid_q && dirty_q;
            if (!(valid_q && dirty_q)) begin
              valid_q      <= 1'b0;
              dirty_q      <= 1'b0;
              flush_done_q <= 1'b1;
            end
          end else if (cpu_req_valid_i) begin
            req_tag_q   <= cpu_tag;
            req_idx_q   <= cpu_idx;
            req_write_q <= cpu_req_write_i;
            req_wdata_q <= cpu_req_wdata_i;
            req_be_q    <= cpu_req_be_i;
            if (hit && cpu_req_write_i) begin
              line_q <= merge_word(line_q, cpu_idx, cpu_req_wdata_i, cpu_req_be_i);
              if (|cpu_req_be_i) dirty_q <= 1'b1;
            end
          end
        end
        ST_WB_WAIT: begin
          if (data_rsp_ready_i && flushing_q) begin
            valid_q      <= 1'b0;
            dirty_q      <= 1'b0;
            flushing_q   <= 1'b0;
            flush_done_q <= 1'b1;
          end
        end
        ST_FILL_WAIT: begin
          if (data_rsp_ready_i) begin
            // Write-allocate: the pending store lands on the freshly filled line.
            line_q  <= req_write_q ? merge_word(data_data_i, req_idx_q, req_wdata_q, req_be_q)
                                   : data_data_i;
            tag_q   <= req_tag_q;
            valid_q <= 1'b1;
            dirty_q <= req_write_q && (|req_be_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sddr_line_buffer.sv
// tb/tb_sddr_line_buffer.sv - directed self-checking bench for sddr_line_buffer
`timescale 1ns/1ps
module tb_sddr_line_buffer;

  localparam int AW = 27;
  localparam int LW = 128;

  localparam logic [LW-1:0] LINE_A  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [LW-1:0] LINE_AM = 128'h01234567_89ABCDEF_FEADBAEF_76543210;
  localparam logic [LW-1:0] LINE_B  = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
  localparam logic [LW-1:0] LINE_BM = 128'hA0A1A2A3_11223344_C0C1C2C3_D0D1D2D3;
  localparam logic [LW-1:0] LINE_C  = 128'h55556666_77778888_9999AAAA_BBBBCCCC;
  localparam logic [LW-1:0] LINE_X  = 128'hDEAD0000_DEAD1111_DEAD2222_DEAD3333;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          cpu_req_valid_i;
  logic          cpu_req_ready_o;
  logic [AW-1:0] cpu_req_addr_i;
  logic          cpu_req_write_i;
  logic [31:0]   cpu_req_wdata_i;
  logic [3:0]    cpu_req_be_i;
  logic          cpu_rsp_valid_o;
  logic [31:0]   cpu_rsp_rdata_o;
  logic          flush_i;
  logic          flush_done_o;
  logic          data_cmd_valid_o;
  logic [AW-1:0] data_cmd_address_o;
  logic          data_cmd_write_o;
  logic          data_cmd_ack_i;
  logic [LW-1:0] data_cmd_data_o;
  logic          data_rsp_ready_i;
  logic [LW-1:0] data_data_i;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sddr_line_buffer dut (
    .cpu_clock_i        (clk),
    .reset_i            (reset_i),
    .cpu_req_valid_i    (cpu_req_valid_i),
    .cpu_req_ready_o    (cpu_req_ready_o),
    .cpu_req_addr_i     (cpu_req_addr_i),
    .cpu_req_write_i    (cpu_req_write_i),
    .cpu_req_wdata_i    (cpu_req_wdata_i),
    .cpu_req_be_i       (cpu_req_be_i),
    .cpu_rsp_valid_o    (cpu_rsp_valid_o),
    .cpu_rsp_rdata_o    (cpu_rsp_rdata_o),
    .flush_i            (flush_i),
    .flush_done_o       (flush_done_o),
    .data_cmd_valid_o   (data_cmd_valid_o),
    .data_cmd_address_o (data_cmd_address_o),
    .data_cmd_write_o   (data_cmd_write_o),
    .data_cmd_ack_i     (data_cmd_ack_i),
    .data_cmd_data_o    (data_cmd_data_o),
    .data_rsp_ready_i   (data_rsp_ready_i),
    .data_data_i        (data_data_i)
  );

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input string tag, input logic [AW-1:0] addr, input logic wr,
                     input logic [31:0] wdata, input logic [3:0] be);
    chk({tag, " ready"}, cpu_req_ready_o, 1'b1);
    cpu_req_valid_i = 1'b1;
    cpu_req_addr_i  = addr;
    cpu_req_write_i = wr;
    cpu_req_wdata_i = wdata;
    cpu_req_be_i    = be;
    tick();
    cpu_req_valid_i = 1'b0;
    cpu_req_addr_i  = '0;
    cpu_req_write_i = 1'b0;
    cpu_req_wdata_i = '0;
    cpu_req_be_i    = '0;
  endtask

  task automatic ddr_xfer(input string tag, input logic exp_write, input logic [AW-1:0] exp_addr,
                          input logic [LW-1:0] exp_data, input int hold, input logic [LW-1:0] rd_line);
    int n = 0;
    while (!data_cmd_valid_o && n < 10) begin
      tick();
      n++;
    end
    chk({tag, " cmd_valid"}, data_cmd_valid_o, 1'b1);
    chk({tag, " cmd_write"}, data_cmd_write_o, exp_write);
    chk({tag, " cmd_addr"}, data_cmd_address_o, exp_addr);
    if (exp_write) chk({tag, " cmd_data"}, data_cmd_data_o, exp_data);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, " hold ctl"}, {data_cmd_valid_o, data_cmd_write_o, data_cmd_address_o},
          {1'b1, exp_write, exp_addr});
      if (exp_write) chk({tag, " hold data"}, data_cmd_data_o, exp_data);
    end
    data_cmd_ack_i = 1'b1;
    tick();
    data_cmd_ack_i = 1'b0;
    chk({tag, " cmd drop"}, data_cmd_valid_o, 1'b0);
    tick();
    chk({tag, " no reissue"}, data_cmd_valid_o, 1'b0);
    data_data_i      = rd_line;
    data_rsp_ready_i = 1'b1;
    tick();
    data_rsp_ready_i = 1'b0;
    data_data_i      = '0;
  endtask

  task automatic wait_rsp(input string tag, input logic [31:0] exp_rdata);
    int n = 0;
    while (!cpu_rsp_valid_o && n < 6) begin
      tick();
      n++;
    end
    chk({tag, " rsp_valid"}, cpu_rsp_valid_o, 1'b1);
    chk({tag, " rdata"}, cpu_rsp_rdata_o, exp_rdata);
    tick();
  endtask

  initial begin
    reset_i          = 1'b1;
    cpu_req_valid_i  = 1'b0;
    cpu_req_addr_i   = '0;
    cpu_req_write_i  = 1'b0;
    cpu_req_wdata_i  = '0;
    cpu_req_be_i     = '0;
    flush_i          = 1'b0;
    data_cmd_ack_i   = 1'b0;
    data_rsp_ready_i = 1'b0;
    data_data_i      = '0;
    repeat (3) tick();
    reset_i = 1'b0;

    chk("rst ready", cpu_req_ready_o, 1'b1);
    chk("rst rsp_valid", cpu_rsp_valid_o, 1'b0);
    chk("rst rdata", cpu_rsp_rdata_o, 32'h0);
    chk("rst flush_done", flush_done_o, 1'b0);
    chk("rst cmd_valid", data_cmd_valid_o, 1'b0);
    chk("rst cmd_addr", data_cmd_address_o, 27'h0);
    chk("rst cmd_write", data_cmd_write_o, 1'b0);

    // Cold load miss: one read, no writeback.
    req("ldA", 27'h0000100, 1'b0, 32'h0, 4'h0);
    chk("ldA cmd at N+1", data_cmd_valid_o, 1'b1);
    chk("ldA busy", cpu_req_ready_o, 1'b0);
    ddr_xfer("fillA", 1'b0, 27'h0000100, '0, 0, LINE_A);
    wait_rsp("ldA", 32'h76543210);

    // Store hit with partial byte enables.
    req("stA", 27'h0000104, 1'b1, 32'hDEADBEEF, 4'b0101);
    chk("stA rsp N+1", cpu_rsp_valid_o, 1'b1);
    chk("stA rdata", cpu_rsp_rdata_o, 32'hFEADBAEF);
    chk("stA no ddr", data_cmd_valid_o, 1'b0);
    tick();

    req("ldA3", 27'h000010C, 1'b0, 32'h0, 4'h0);
    chk("ldA3 rsp N+1", cpu_rsp_valid_o, 1'b1);
    chk("ldA3 rdata", cpu_rsp_rdata_o, 32'h01234567);
    chk("ldA3 no ddr", data_cmd_valid_o, 1'b0);
    tick();

    // Dirty miss: writeback of merged line with delayed ack, then fill.
    req("ldB", 27'h0000200, 1'b0, 32'h0, 4'h0);
    ddr_xfer("wbA", 1'b1, 27'h0000100, LINE_AM, 5, '0);
    ddr_xfer("fillB", 1'b0, 27'h0000200, '0, 0, LINE_B);
    wait_rsp("ldB", 32'hD0D1D2D3);

    req("stB", 27'h0000208, 1'b1, 32'h11223344, 4'b1111);
    chk("stB rsp N+1", cpu_rsp_valid_o, 1'b1);
    chk("stB rdata", cpu_rsp_rdata_o, 32'h11223344);
    tick();

    // Dirty flush colliding with a request: flush wins.
    flush_i         = 1'b1;
    cpu_req_valid_i = 1'b1;
    cpu_req_addr_i  = 27'h0000100;
    #1;
    chk("flush blocks ready", cpu_req_ready_o, 1'b0);
    tick();
    flush_i         = 1'b0;
    cpu_req_valid_i = 1'b0;
    cpu_req_addr_i  = '0;
    ddr_xfer("flushwb", 1'b1, 27'h0000200, LINE_BM, 0, '0);
    chk("flush1 done", flush_done_o, 1'b1);
    chk("flush1 no rsp", cpu_rsp_valid_o, 1'b0);
    tick();
    chk("flush1 done pulse", flush_done_o, 1'b0);

    // Clean flush: done the next cycle, no DDR command.
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush2 done", flush_done_o, 1'b1);
    chk("flush2 no ddr", data_cmd_valid_o, 1'b0);
    tick();
    chk("flush2 done pulse", flush_done_o, 1'b0);
    chk("flush2 still no ddr", data_cmd_valid_o, 1'b0);

    // Invalidated line misses; reset lands in FILL_WAIT and the late completion is ignored.
    req("ldR", 27'h0000200, 1'b0, 32'h0, 4'h0);
    chk("ldR cmd_valid", data_cmd_valid_o, 1'b1);
    chk("ldR cmd_write", data_cmd_write_o, 1'b0);
    chk("ldR cmd_addr", data_cmd_address_o, 27'h0000200);
    data_cmd_ack_i = 1'b1;
    tick();
    data_cmd_ack_i = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("mid rst ready", cpu_req_ready_o, 1'b1);
    chk("mid rst cmd_valid", data_cmd_valid_o, 1'b0);
    data_data_i      = LINE_X;
    data_rsp_ready_i = 1'b1;
    tick();
    data_rsp_ready_i = 1'b0;
    data_data_i      = '0;
    chk("stale rsp no cpu rsp", cpu_rsp_valid_o, 1'b0);
    chk("stale rsp ready", cpu_req_ready_o, 1'b1);

    req("ldC", 27'h0000200, 1'b0, 32'h0, 4'h0);
    chk("ldC cmd at N+1", data_cmd_valid_o, 1'b1);
    ddr_xfer("fillC", 1'b0, 27'h0000200, '0, 0, LINE_C);
    wait_rsp("ldC", 32'hBBBBCCCC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
